// File: rtl/exp_env_pkg.sv
// Shared definitions for the ROM-to-RAM copy and RAM read-back environments.
// Keeps FSM encoding and RAM geometry identical on both sides of the RAM.
package exp_env_pkg;

  localparam int ENV_DEPTH  = 16;
  localparam int ENV_ADDR_W = 4;
  localparam int ENV_DATA_W = 8;
  localparam int ENV_RD_LAT = 2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/ram_read_delay.sv
// RD_LAT-stage shift register carrying {valid, addr} alongside a RAM read,
// so the tail lines up with the cycle the RAM returns that word.
module ram_read_delay #(
  parameter int RD_LAT = 2,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              tail_valid,
  output logic [ADDR_W-1:0] tail_addr,
  output logic              pending
);

  logic [RD_LAT-1:0] vld;
  logic [ADDR_W-1:0] adr [RD_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        adr[i] <= '0;
      end
    end else begin
      vld[0] <= in_valid;
      adr[0] <= in_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        vld[i] <= vld[i-1];
        adr[i] <= adr[i-1];
      end
    end
  end

  assign tail_valid = vld[RD_LAT-1];
  assign tail_addr  = adr[RD_LAT-1];
  assign pending    = |vld;

endmodule

// File: rtl/ram_read_env.sv
// RAM read-back engine: bursts DEPTH sequential reads on start, returns each
// word with its address and a running checksum, then pulses done.
module ram_read_env
  import exp_env_pkg::*;
#(
  parameter int DEPTH  = ENV_DEPTH,
  parameter int ADDR_W = ENV_ADDR_W,
  parameter int DATA_W = ENV_DATA_W,
  parameter int RD_LAT = ENV_RD_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_sig,
  output logic              done_sig,
  output logic              read_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_data,
  output logic              data_valid,
  output logic [DATA_W-1:0] data_out,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state_q;
  state_t            state_d;
  logic              tail_valid;
  logic [ADDR_W-1:0] tail_addr;
  logic              pending;
  logic              launch;

  ram_read_delay #(
    .RD_LAT (RD_LAT),
    .ADDR_W (ADDR_W)
  ) u_dly (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (read_en),
    .in_addr    (ram_addr),
    .tail_valid (tail_valid),
    .tail_addr  (tail_addr),
    .pending    (pending)
  );

  assign launch = (state_q == IDLE) && start_sig;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start_sig) state_d = ISSUE;
      ISSUE: if (ram_addr == LAST) state_d = DRAIN;
      DRAIN: if (!pending) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read side: strobe/address follow the next state so they are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_en  <= 1'b0;
      ram_addr <= '0;
      done_sig <= 1'b0;
    end else begin
      read_en  <= (state_d == ISSUE);
      done_sig <= (state_d == DONE);
      if (launch) begin
        ram_addr <= '0;
      end else if (state_q == ISSUE && state_d == ISSUE) begin
        ram_addr <= ram_addr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_valid <= 1'b0;
      data_out   <= '0;
      data_addr  <= '0;
      checksum   <= '0;
    end else begin
      data_valid <= tail_valid;
      if (tail_valid) begin
        data_out  <= ram_data;
        data_addr <= tail_addr;
      end
      if (launch) begin
        checksum <= '0;
      end else if (tail_valid) begin
        checksum <= checksum + ram_data;
      end
    end
  end

endmodule

// File: tb/tb_ram_read_env.sv
// Scoreboard bench for ram_read_env at read latencies 2, 1 and 4.
module tb_ram_read_env;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst   [3];
  logic       start [3];
  logic       done  [3];
  logic       ren   [3];
  logic       dv    [3];
  logic [3:0] raddr [3];
  logic [3:0] daddr [3];
  logic [7:0] rdata [3];
  logic [7:0] dout  [3];
  logic [7:0] ck    [3];

  logic [7:0] mem [16];

  int n_cmp = 0;
  int n_err = 0;

  int         t0       [3];
  bit         armed    [3];
  logic [7:0] exp_ck   [3];
  logic [7:0] sum      [3];
  int         done_cnt [3];
  int         done_cyc [3];

  logic [11:0] q0[$];
  logic [11:0] q1[$];
  logic [11:0] q2[$];

  for (genvar g = 0; g < 3; g++) begin : g_env
    localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    logic [7:0] pipe [L];

    ram_read_env #(
      .RD_LAT (L)
    ) u_dut (
      .clk        (clk),
      .rst        (rst[g]),
      .start_sig  (start[g]),
      .done_sig   (done[g]),
      .read_en    (ren[g]),
      .ram_addr   (raddr[g]),
      .ram_data   (rdata[g]),
      .data_valid (dv[g]),
      .data_out   (dout[g]),
      .data_addr  (daddr[g]),
      .checksum   (ck[g])
    );

    always @(posedge clk) begin
      pipe[0] <= ren[g] ? mem[raddr[g]] : 8'hA5;
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end

    assign rdata[g] = pipe[L-1];
  end

  function automatic int lat_of(int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 4);
  endfunction

  function automatic void qpush(int g, logic [11:0] v);
    if (g == 0) q0.push_back(v);
    else if (g == 1) q1.push_back(v);
    else q2.push_back(v);
  endfunction

  function automatic int qsize(int g);
    return (g == 0) ? q0.size() : ((g == 1) ? q1.size() : q2.size());
  endfunction

  function automatic logic [11:0] qpop(int g);
    if (g == 0) return q0.pop_front();
    else if (g == 1) return q1.pop_front();
    return q2.pop_front();
  endfunction

  function automatic void qclr(int g);
    if (g == 0) q0.delete();
    else if (g == 1) q1.delete();
    else q2.delete();
  endfunction

  task automatic chk(string nm, int g, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h",
               nm, g, cyc, got, want);
    end
  endtask

  task automatic chk_zero(int g);
    chk("rst_zero", g,
        {5'b0, done[g], ren[g], raddr[g], dv[g], dout[g], daddr[g], ck[g]},
        32'h0);
  endtask

  // Monitor: runs mid-cycle, compares against the expectation queues.
  task automatic mon(int g);
    int L = lat_of(g);
    int k = cyc - t0[g];
    bit act;
    bit exp_ren;
    bit exp_done;
    logic [11:0] e;
    act      = armed[g] && k >= 0 && k <= DEPTH + L + 1;
    exp_ren  = act && k < DEPTH;
    exp_done = act && k == DEPTH + L + 1;
    chk("read_en", g, ren[g], exp_ren);
    if (exp_ren) chk("ram_addr", g, raddr[g], k);
    if (act && k == 0) sum[g] = 8'h00;
    if (dv[g]) begin
      if (qsize(g) == 0) begin
        chk("spurious_dv", g, dv[g], 0);
      end else begin
        e = qpop(g);
        chk("word", g, {daddr[g], dout[g]}, e);
        sum[g] += e[7:0];
      end
    end
    if (act) chk("checksum_run", g, ck[g], sum[g]);
    chk("done_sig", g, done[g], exp_done);
    if (done[g]) begin
      done_cnt[g]++;
      done_cyc[g] = cyc;
      if (exp_done) begin
        chk("checksum_final", g, ck[g], exp_ck[g]);
        chk("words_left", g, qsize(g), 0);
      end
    end
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) mon(g);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic arm(int g, bit ff, logic [7:0] cke, int t);
    t0[g] = t;
    exp_ck[g] = cke;
    qclr(g);
    for (int k = 0; k < DEPTH; k++) begin
      qpush(g, {4'(k), ff ? 8'hFF : 8'(3 * k)});
    end
    armed[g] = 1'b1;
  endtask

  task automatic go(int g, bit ff, logic [7:0] cke);
    start[g] = 1'b1;
    arm(g, ff, cke, cyc + 1);
  endtask

  task automatic wait_done(int g);
    int prev = done_cnt[g];
    int n = 0;
    while (done_cnt[g] == prev && n < 300) begin
      tick();
      n++;
    end
    n_cmp++;
    if (done_cnt[g] == prev) begin
      n_err++;
      $display("FAIL timeout dut%0d got no done_sig want done_sig", g);
    end
  endtask

  initial begin
    for (int g = 0; g < 3; g++) begin
      rst[g] = 1'b1;
      start[g] = 1'b0;
      armed[g] = 1'b0;
      t0[g] = 0;
      done_cnt[g] = 0;
      done_cyc[g] = 0;
      sum[g] = 8'h00;
      exp_ck[g] = 8'h00;
    end
    for (int k = 0; k < DEPTH; k++) mem[k] = 8'(3 * k);
    repeat (3) tick();
    for (int g = 0; g < 3; g++) chk_zero(g);
    for (int g = 0; g < 3; g++) rst[g] = 1'b0;
    repeat (2) tick();

    // master loop: start held, second run starts after one IDLE cycle
    go(0, 1'b0, 8'h68);
    wait_done(0);
    arm(0, 1'b0, 8'h68, done_cyc[0] + 2);
    wait_done(0);
    start[0] = 1'b0;
    repeat (3) tick();

    // start dropped in cycle 5 does not abort
    go(0, 1'b0, 8'h68);
    while (cyc - t0[0] < 5) tick();
    start[0] = 1'b0;
    wait_done(0);
    repeat (2) tick();

    // reset in cycle 8, then idle, then a fresh run
    go(0, 1'b0, 8'h68);
    while (cyc - t0[0] < 8) tick();
    armed[0] = 1'b0;
    qclr(0);
    start[0] = 1'b0;
    rst[0] = 1'b1;
    #1 chk_zero(0);
    tick();
    rst[0] = 1'b0;
    repeat (10) tick();
    go(0, 1'b0, 8'h68);
    wait_done(0);
    start[0] = 1'b0;
    repeat (2) tick();

    // latency 1 and 4 variants
    go(1, 1'b0, 8'h68);
    go(2, 1'b0, 8'h68);
    wait_done(1);
    start[1] = 1'b0;
    wait_done(2);
    start[2] = 1'b0;
    repeat (2) tick();

    // checksum wrap-around
    for (int k = 0; k < DEPTH; k++) mem[k] = 8'hFF;
    go(0, 1'b1, 8'hF0);
    wait_done(0);
    start[0] = 1'b0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
